// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- producer-side handshake for uart_tx_fifo.
//
// Signals:
//   data_in     word offered by the producer (DATA_BITS wide)
//   data_valid  producer presents data_in
//   data_ready  transmitter FIFO can accept; transfer on valid && ready at clk rise
//
// Modports:
//   master  producer side (drives data_in/data_valid)
//   slave   transmitter side (drives data_ready)
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 data_valid;
    logic                 data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered, parametrised UART transmitter (idle-high line).
//
// A small input FIFO queues words from the producer; the frame FSM pops the
// head and shifts it out as start bit, DATA_BITS payload bits (LSB first),
// optional parity bit and STOP_BITS stop bits. Consecutive queued words are
// sent with no idle gap between frames.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   push        uart_tx_fifo_if.slave: data_in / data_valid / data_ready
//   tx          registered serial output, idle high
//   busy        frame on the line or FIFO non-empty
//   fifo_level  queued words, excluding the word being shifted
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit (XOR of payload ^ PARITY_ODD)
//                      follows the data bits. When undefined, PARITY_ODD is
//                      only range-checked.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               push,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    // Reject unsupported parameter sets at elaboration.
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_fifo: unsupported parameter set");
    end

`ifdef UART_TX_PARITY_EN
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] STOP   = 3'd3;
    localparam logic [STATE_W-1:0] PARITY = 3'd4;
`else
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] START  = 2'd1;
    localparam logic [STATE_W-1:0] DATA   = 2'd2;
    localparam logic [STATE_W-1:0] STOP   = 2'd3;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       level;
    logic                 full;
    logic                 empty;
    logic                 push_fire;
    logic                 pop_fire;
    logic [DATA_BITS-1:0] head;

    // Frame engine
    logic [STATE_W-1:0]   state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Ready follows stored level only, so a pop in the same cycle cannot
    // open a slot for a push while full.
    assign push.data_ready = !rst && !full;
    assign push_fire       = push.data_valid && push.data_ready;

    assign bit_end  = (cnt == CNT_LAST);
    // Pop from IDLE, or on the very last stop-bit cycle to chain frames.
    assign pop_fire = !empty &&
                      ((state == IDLE) ||
                       (state == STOP && bit_end && bit_idx == STOP_LAST));

    assign fifo_level = level;
    assign busy       = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                    if (pop_fire) begin
                        shreg      <= head;
                        tx         <= 1'b0;
                        state      <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // tx always shows shreg[0]; the register shifts at each
                // bit boundary so the next bit is shreg[1].
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop_fire) begin
                                shreg      <= head;
                                tx         <= 1'b0;
                                state      <= START;
`ifdef UART_TX_PARITY_EN
                                parity_bit <= (^head) ^ 1'(PARITY_ODD);
`endif
                            end else begin
                                tx    <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- directed bench for uart_tx_fifo.
// u_dut: default configuration; u_sweep: CLKS_PER_BIT=3, DATA_BITS=7,
// STOP_BITS=2; u_odd (parity builds only): PARITY_ODD=1.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
    logic       tx0, busy0;
    logic [2:0] lvl0;

    uart_tx_fifo #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut (
        .clk(clk), .rst(rst), .push(bus0), .tx(tx0), .busy(busy0), .fifo_level(lvl0)
    );

    uart_tx_fifo_if #(.DATA_BITS(7)) bus1 ();
    logic       tx1, busy1;
    logic [2:0] lvl1;

    uart_tx_fifo #(
        .CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_sweep (
        .clk(clk), .rst(rst), .push(bus1), .tx(tx1), .busy(busy1), .fifo_level(lvl1)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_fifo_if #(.DATA_BITS(8)) bus2 ();
    logic       tx2, busy2;
    logic [2:0] lvl2;

    uart_tx_fifo #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) u_odd (
        .clk(clk), .rst(rst), .push(bus2), .tx(tx2), .busy(busy2), .fifo_level(lvl2)
    );
`endif

    function automatic logic tx_of(input int w);
        case (w)
            1:       return tx1;
`ifdef UART_TX_PARITY_EN
            2:       return tx2;
`endif
            default: return tx0;
        endcase
    endfunction

    // Waits (bounded) for a start bit, then samples mid-bit for a whole frame.
    // Returns at the negedge just after the frame's last cycle.
    task automatic rx_frame(input int w, input int cpb, input int nbits, input int nstop,
                            output logic [15:0] fb, output int waited, output bit timed_out);
        int total;
        total     = 1 + nbits + PB + nstop;
        fb        = '0;
        waited    = 0;
        timed_out = 1'b0;
        while (tx_of(w) !== 1'b0) begin
            if (waited >= 300) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
            waited++;
        end
        for (int c = 0; c < total * cpb; c++) begin
            if (c % cpb == cpb / 2) fb[c / cpb] = tx_of(w);
            @(negedge clk);
        end
    endtask

    function automatic logic [8:0] fb_data(input logic [15:0] fb, input int nbits);
        logic [8:0] d;
        d = '0;
        for (int i = 0; i < nbits; i++) d[i] = fb[i + 1];
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus0.data_valid = 1'b0; bus0.data_in = '0;
        bus1.data_valid = 1'b0; bus1.data_in = '0;
`ifdef UART_TX_PARITY_EN
        bus2.data_valid = 1'b0; bus2.data_in = '0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", lvl0); end
        checks++; if (bus0.data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus0.data_ready); end
        checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx_sweep: got %b expected 1", tx1); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", bus0.data_ready); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy0); end
    endtask

    task automatic test_single_byte();
        logic [7:0]  b;
        logic [15:0] eb;
        int          total;
        b     = 8'hA5;
        total = 1 + 8 + PB + 1;
        eb    = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[1 + i] = b[i];
        if (PB == 1) eb[9] = ^b;
        checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", bus0.data_ready); end
        bus0.data_in = b; bus0.data_valid = 1'b1;
        @(negedge clk);
        bus0.data_valid = 1'b0;
        checks++; if (lvl0 !== 3'd1) begin errors++; $display("FAIL single_level_after_accept: got %0d expected 1", lvl0); end
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL single_tx_before_pop: got %b expected 1", tx0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy_queued: got %b expected 1", busy0); end
        @(negedge clk);
        checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL single_level_after_pop: got %0d expected 0", lvl0); end
        for (int k = 0; k < total * 4; k++) begin
            checks++;
            if (tx0 !== eb[k / 4]) begin errors++; $display("FAIL single_line cycle %0d: got %b expected %b", k, tx0, eb[k / 4]); end
            if (k == total * 4 - 1) begin
                checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy0); end
            end
            @(negedge clk);
        end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy0); end
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL single_tx_end: got %b expected 1", tx0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        logic [2:0] exp_lvl [4];
        vals    = '{8'h00, 8'hFF, 8'h55, 8'h0F};
        exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3};
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready word %0d: got %b expected 1", i, bus0.data_ready); end
                    bus0.data_in = vals[i]; bus0.data_valid = 1'b1;
                    @(negedge clk);
                    checks++; if (lvl0 !== exp_lvl[i]) begin errors++; $display("FAIL b2b_level word %0d: got %0d expected %0d", i, lvl0, exp_lvl[i]); end
                end
                bus0.data_valid = 1'b0;
            end
            begin
                logic [15:0] fb;
                int          waited;
                bit          to;
                for (int f = 0; f < 4; f++) begin
                    rx_frame(0, 4, 8, 1, fb, waited, to);
                    checks++; if (to) begin errors++; $display("FAIL b2b_timeout frame %0d: got timeout expected start bit", f); end
                    checks++; if (fb_data(fb, 8) !== {1'b0, vals[f]}) begin errors++; $display("FAIL b2b_data frame %0d: got %h expected %h", f, fb_data(fb, 8), vals[f]); end
                    checks++; if (fb[9 + PB] !== 1'b1) begin errors++; $display("FAIL b2b_stop frame %0d: got %b expected 1", f, fb[9 + PB]); end
                    if (f > 0) begin
                        checks++; if (waited !== 0) begin errors++; $display("FAIL b2b_gap frame %0d: got %0d idle cycles expected 0", f, waited); end
                    end
                end
            end
        join
    endtask

    task automatic test_full_fifo();
        logic [7:0] vals [6];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                int n;
                checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL full_ready_first: got %b expected 1", bus0.data_ready); end
                bus0.data_in = vals[0]; bus0.data_valid = 1'b1;
                @(negedge clk);
                bus0.data_valid = 1'b0;
                repeat (8) @(negedge clk);
                for (int i = 1; i < 5; i++) begin
                    checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL full_ready word %0d: got %b expected 1", i, bus0.data_ready); end
                    bus0.data_in = vals[i]; bus0.data_valid = 1'b1;
                    @(negedge clk);
                end
                bus0.data_in = vals[5];
                checks++; if (lvl0 !== 3'd4) begin errors++; $display("FAIL full_level: got %0d expected 4", lvl0); end
                checks++; if (bus0.data_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b expected 0", bus0.data_ready); end
                n = 0;
                while (bus0.data_ready !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++; if (n >= 200) begin errors++; $display("FAIL full_release: got no ready within %0d cycles expected ready", n); end
                checks++; if (lvl0 !== 3'd3) begin errors++; $display("FAIL full_level_release: got %0d expected 3", lvl0); end
                @(negedge clk);
                bus0.data_valid = 1'b0;
                checks++; if (lvl0 !== 3'd4) begin errors++; $display("FAIL full_level_refill: got %0d expected 4", lvl0); end
                checks++; if (bus0.data_ready !== 1'b0) begin errors++; $display("FAIL full_ready_refill: got %b expected 0", bus0.data_ready); end
            end
            begin
                logic [15:0] fb;
                int          waited;
                bit          to;
                for (int f = 0; f < 6; f++) begin
                    rx_frame(0, 4, 8, 1, fb, waited, to);
                    checks++; if (to) begin errors++; $display("FAIL full_timeout frame %0d: got timeout expected start bit", f); end
                    checks++; if (fb_data(fb, 8) !== {1'b0, vals[f]}) begin errors++; $display("FAIL full_data frame %0d: got %h expected %h", f, fb_data(fb, 8), vals[f]); end
                    if (f > 0) begin
                        checks++; if (waited !== 0) begin errors++; $display("FAIL full_gap frame %0d: got %0d idle cycles expected 0", f, waited); end
                    end
                end
            end
        join
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy0); end
    endtask

    task automatic test_reset_mid_frame();
        bit bad;
        bus0.data_in = 8'h3C; bus0.data_valid = 1'b1;
        @(negedge clk);
        bus0.data_in = 8'hAA;
        @(negedge clk);
        bus0.data_in = 8'hBB;
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL rmf_start: got %b expected 0", tx0); end
        @(negedge clk);
        bus0.data_valid = 1'b0;
        repeat (16) @(negedge clk);
        // cycle 17 of the frame: inside data bit 3 (cycles 16..19), 0x3C bit 3 = 1
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL rmf_bit3: got %b expected 1", tx0); end
        checks++; if (lvl0 !== 3'd2) begin errors++; $display("FAIL rmf_level_before: got %0d expected 2", lvl0); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL rmf_tx: got %b expected 1", tx0); end
        checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL rmf_level: got %0d expected 0", lvl0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy0); end
        checks++; if (bus0.data_ready !== 1'b0) begin errors++; $display("FAIL rmf_ready_in_reset: got %b expected 0", bus0.data_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus0.data_ready !== 1'b1) begin errors++; $display("FAIL rmf_ready_after: got %b expected 1", bus0.data_ready); end
        bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin errors++; $display("FAIL rmf_quiet: got line activity after reset expected idle"); end
    endtask

    task automatic test_config_sweep();
        logic [6:0]  b;
        logic [15:0] eb;
        int          total;
        b     = 7'h41;
        total = 1 + 7 + PB + 2;
        eb    = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < 7; i++) eb[1 + i] = b[i];
        if (PB == 1) eb[8] = ^b;
        bus1.data_in = b; bus1.data_valid = 1'b1;
        @(negedge clk);
        bus1.data_valid = 1'b0;
        checks++; if (lvl1 !== 3'd1) begin errors++; $display("FAIL sweep_level: got %0d expected 1", lvl1); end
        @(negedge clk);
        for (int k = 0; k < total * 3; k++) begin
            checks++;
            if (tx1 !== eb[k / 3]) begin errors++; $display("FAIL sweep_line cycle %0d: got %b expected %b", k, tx1, eb[k / 3]); end
            @(negedge clk);
        end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sweep_busy_end: got %b expected 0", busy1); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] eb;
        logic [15:0] fb;
        int          waited;
        bit          to;
        // 0x07 LSB first, even parity 1, one stop bit: 11 bits
        eb = 16'b0000_0110_0000_1110;
        bus0.data_in = 8'h07; bus0.data_valid = 1'b1;
        @(negedge clk);
        bus0.data_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 44; k++) begin
            checks++;
            if (tx0 !== eb[k / 4]) begin errors++; $display("FAIL parity_even_line cycle %0d: got %b expected %b", k, tx0, eb[k / 4]); end
            @(negedge clk);
        end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL parity_busy_end: got %b expected 0", busy0); end
        bus2.data_in = 8'h07; bus2.data_valid = 1'b1;
        @(negedge clk);
        bus2.data_valid = 1'b0;
        rx_frame(2, 4, 8, 1, fb, waited, to);
        checks++; if (to) begin errors++; $display("FAIL parity_odd_timeout: got timeout expected start bit"); end
        checks++; if (fb[9] !== 1'b0) begin errors++; $display("FAIL parity_odd_bit: got %b expected 0", fb[9]); end
        checks++; if (fb_data(fb, 8) !== 9'h007) begin errors++; $display("FAIL parity_odd_data: got %h expected 07", fb_data(fb, 8)); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid_frame();
        test_config_sweep();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
